// File: rtl/spi_tx_arbiter_if.sv
// Requester-side and engine-side signals of the SPI transmit frame arbiter.
// Requesters drive through master; the arbiter attaches as slave.
interface spi_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic                 underrun;
    logic [7:0]           spi_data;
    logic                 spi_enable;

    modport master (
        output req_valid, req_last, req_data,
        input  req_ready, grant, busy, underrun, spi_data, spi_enable
    );

    modport slave (
        input  req_valid, req_last, req_data,
        output req_ready, grant, busy, underrun, spi_data, spi_enable
    );
endinterface

// File: rtl/spi_tx_arbiter.sv
// Frame-level scheduler sharing one mode-0 SPI transmit engine between NUM_REQ byte streams.
// Define SPI_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module spi_tx_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int CS_GAP  = 2
) (
    input  logic             clk,
    input  logic             rst,
    spi_tx_arbiter_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               und_q, und_d;
    logic               en_q, en_d;
    logic               last_q, last_d;
    logic [7:0]         data_q, data_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [3:0]         gap_cnt_q, gap_cnt_d;
`ifndef SPI_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
`endif

    logic               found;
    logic [IDX_W-1:0]   winner;
    logic [7:0]         req_bytes [NUM_REQ];
    logic [7:0]         cur_byte;
    logic               owner_valid;
    logic               owner_last;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = bus.req_data[8*i +: 8];
        end
    end

    assign cur_byte    = req_bytes[owner_q];
    assign owner_valid = bus.req_valid[owner_q];
    assign owner_last  = bus.req_last[owner_q];

    // First valid requester scanning upward from the search start, wrapping past NUM_REQ-1.
    always_comb begin
        int j;
        j      = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef SPI_ARB_FIXED_PRIO_EN
            j = k;
`else
            j = int'(rr_ptr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
`endif
            if (!found && bus.req_valid[j[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = j[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ready_d   = '0;
        busy_d    = busy_q;
        und_d     = 1'b0;
        en_d      = en_q;
        last_d    = last_q;
        data_d    = data_q;
        owner_d   = owner_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
`ifndef SPI_ARB_FIXED_PRIO_EN
        rr_ptr_d  = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = NUM_REQ'(1) << winner;
                    owner_d = winner;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (owner_valid) begin
                    data_d    = cur_byte;
                    last_d    = owner_last;
                    ready_d   = grant_q;
                    en_d      = 1'b1;
                    bit_cnt_d = 3'd0;
                    state_d   = SHIFT;
                end else begin
                    und_d   = 1'b1;
                    state_d = GAP;
                end
            end
            SHIFT: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                // The engine cannot stall, so a missing next byte aborts the frame.
                if (bit_cnt_q == 3'd7) begin
                    if (last_q) begin
                        en_d    = 1'b0;
                        state_d = GAP;
                    end else if (owner_valid) begin
                        data_d  = cur_byte;
                        last_d  = owner_last;
                        ready_d = grant_q;
                    end else begin
                        en_d    = 1'b0;
                        und_d   = 1'b1;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == 4'(CS_GAP - 1)) begin
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    gap_cnt_d = 4'd0;
`ifndef SPI_ARB_FIXED_PRIO_EN
                    rr_ptr_d  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
`endif
                    state_d   = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ready_q   <= '0;
            busy_q    <= 1'b0;
            und_q     <= 1'b0;
            en_q      <= 1'b0;
            last_q    <= 1'b0;
            data_q    <= 8'h00;
            owner_q   <= '0;
            bit_cnt_q <= 3'd0;
            gap_cnt_q <= 4'd0;
`ifndef SPI_ARB_FIXED_PRIO_EN
            rr_ptr_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            und_q     <= und_d;
            en_q      <= en_d;
            last_q    <= last_d;
            data_q    <= data_d;
            owner_q   <= owner_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
`ifndef SPI_ARB_FIXED_PRIO_EN
            rr_ptr_q  <= rr_ptr_d;
`endif
        end
    end

    assign bus.grant      = grant_q;
    assign bus.req_ready  = ready_q;
    assign bus.busy       = busy_q;
    assign bus.underrun   = und_q;
    assign bus.spi_data   = data_q;
    assign bus.spi_enable = en_q;
endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Bench for spi_tx_arbiter: requester byte queues, a wire-level monitor of the engine view,
// and a frame-level arbitration model (round-robin, or fixed priority with SPI_ARB_FIXED_PRIO_EN).
module tb_spi_tx_arbiter;
    localparam int NR   = 2;
    localparam int GAPC = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

    spi_tx_arbiter #(.NUM_REQ(NR), .CS_GAP(GAPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Requester byte streams
    logic [7:0] src_d [NR][64];
    bit         src_l [NR][64];
    int         head  [NR];
    int         tail  [NR];

    // Monitor state
    int          cyc = 0;
    int          drive_cyc;
    bit          prev_en = 0, prev_busy = 0;
    int          fr_len = 0;
    logic [7:0]  fr_byte, prev_data;
    logic [NR-1:0] fr_grant, rdy_s;
    int          obs_owner[$], obs_len[$], obs_rise[$], obs_fall[$], rdy_cyc[$];
    logic [7:0]  obs_bytes[$];
    int          first_grant, busy_fall, und_cyc, und_cnt, hold_err, multi_rdy;

    // Model expectations
    int          exp_owner[$], exp_len[$];
    logic [7:0]  exp_bytes[$];
    int          mdl_ptr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input bit l);
        src_d[r][tail[r]] = d;
        src_l[r][tail[r]] = l;
        tail[r]++;
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i]       = (head[i] < tail[i]);
            bus.req_data[8*i +: 8] = src_d[i][head[i]];
            bus.req_last[i]        = src_l[i][head[i]];
        end
    endtask

    task automatic flush_src();
        for (int i = 0; i < NR; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
    endtask

    function automatic bit all_empty();
        bit e = 1;
        for (int i = 0; i < NR; i++) if (head[i] < tail[i]) e = 0;
        return e;
    endfunction

    task automatic clear_mon();
        obs_owner.delete(); obs_len.delete(); obs_rise.delete(); obs_fall.delete();
        obs_bytes.delete(); rdy_cyc.delete();
        first_grant = -1; busy_fall = -1; und_cyc = -1;
        und_cnt = 0; hold_err = 0; multi_rdy = 0;
    endtask

    // One clock: observe at the negedge (engine sampling point), then advance requesters after the posedge.
    task automatic step();
        logic [2:0] bp;
        @(negedge clk);
        cyc++;
        rdy_s = bus.req_ready;
        if ($countones(bus.req_ready) > 1) multi_rdy++;
        if (bus.req_ready != '0) rdy_cyc.push_back(cyc);
        if (bus.underrun) begin und_cnt++; und_cyc = cyc; end
        if (bus.grant != '0 && first_grant < 0) first_grant = cyc;
        if (!bus.busy && prev_busy) busy_fall = cyc;
        if (bus.spi_enable) begin
            if (!prev_en) begin
                fr_len   = 0;
                fr_grant = bus.grant;
                obs_rise.push_back(cyc);
            end else if (bus.grant != fr_grant || ((fr_len % 8) != 0 && bus.spi_data != prev_data)) begin
                hold_err++;
            end
            bp = 3'(fr_len % 8);
            fr_byte[bp] = bus.spi_data[bp];
            fr_len++;
            if ((fr_len % 8) == 0) obs_bytes.push_back(fr_byte);
        end else if (prev_en) begin
            obs_owner.push_back(int'(fr_grant));
            obs_len.push_back(fr_len);
            obs_fall.push_back(cyc);
        end
        prev_en   = bus.spi_enable;
        prev_busy = bus.busy;
        prev_data = bus.spi_data;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (rdy_s[i] && head[i] < tail[i]) head[i]++;
        drive();
    endtask

    // Whole-frame arbitration order over everything currently queued.
    task automatic build_expect();
        int rd [NR];
        int pick, j, n;
        bit done;
        exp_owner.delete(); exp_len.delete(); exp_bytes.delete();
        for (int i = 0; i < NR; i++) rd[i] = head[i];
        while (1) begin
            pick = -1;
            for (int k = 0; k < NR; k++) begin
`ifdef SPI_ARB_FIXED_PRIO_EN
                j = k;
`else
                j = (mdl_ptr + k) % NR;
`endif
                if (pick < 0 && rd[j] < tail[j]) pick = j;
            end
            if (pick < 0) break;
            n = 0;
            done = 0;
            while (!done) begin
                exp_bytes.push_back(src_d[pick][rd[pick]]);
                done = src_l[pick][rd[pick]] || (rd[pick] + 1 >= tail[pick]);
                rd[pick]++;
                n++;
            end
            exp_owner.push_back(1 << pick);
            exp_len.push_back(8 * n);
`ifndef SPI_ARB_FIXED_PRIO_EN
            mdl_ptr = (pick + 1) % NR;
`endif
        end
    endtask

    task automatic run_scn(input string name);
        bit ok = 0;
        int nf, nb;
        build_expect();
        clear_mon();
        drive();
        drive_cyc = cyc;
        for (int t = 0; t < 3000; t++) begin
            step();
            if (all_empty() && !bus.busy) begin ok = 1; break; end
        end
        step();
        step();
        check($sformatf("%s completes", name), 32'(ok), 32'd1);
        check($sformatf("%s frame count", name), obs_owner.size(), exp_owner.size());
        nf = (obs_owner.size() < exp_owner.size()) ? obs_owner.size() : exp_owner.size();
        for (int f = 0; f < nf; f++) begin
            check($sformatf("%s grant f%0d", name, f), obs_owner[f], exp_owner[f]);
            check($sformatf("%s enable len f%0d", name, f), obs_len[f], exp_len[f]);
            if (f > 0)
                check($sformatf("%s cs gap f%0d", name, f), obs_rise[f] - obs_fall[f-1], GAPC + 2);
        end
        check($sformatf("%s byte count", name), obs_bytes.size(), exp_bytes.size());
        nb = (obs_bytes.size() < exp_bytes.size()) ? obs_bytes.size() : exp_bytes.size();
        for (int b = 0; b < nb; b++)
            check($sformatf("%s wire byte %0d", name, b), obs_bytes[b], exp_bytes[b]);
        check($sformatf("%s ready pulses", name), rdy_cyc.size(), exp_bytes.size());
        check($sformatf("%s hold errors", name), hold_err, 0);
        check($sformatf("%s multi ready", name), multi_rdy, 0);
        check($sformatf("%s underruns", name), und_cnt, 0);
    endtask

    initial begin
        int len, nfr;
        bit ok;
        rst = 1'b1;
        flush_src();
        drive();
        clear_mon();
        repeat (2) @(posedge clk);
        #1;
        check("reset grant",      bus.grant,      '0);
        check("reset busy",       bus.busy,       0);
        check("reset req_ready",  bus.req_ready,  '0);
        check("reset underrun",   bus.underrun,   0);
        check("reset spi_data",   bus.spi_data,   8'h00);
        check("reset spi_enable", bus.spi_enable, 0);
        rst = 1'b0;
        step();

        // Single byte 0xA5 (wire 1,0,1,0,0,1,0,1)
        push(0, 8'hA5, 1);
        run_scn("single");
        check("single grant latency", first_grant - drive_cyc, 2);
        check("single enable latency", (obs_rise.size() > 0) ? obs_rise[0] - drive_cyc : -1, 3);
        check("single busy after enable",
              (obs_fall.size() > 0) ? busy_fall - (obs_fall[0] - 1) : -1, GAPC + 1);

        // Back-to-back three-byte frame from requester 1
        flush_src();
        push(1, 8'h01, 0); push(1, 8'h80, 0); push(1, 8'hFF, 1);
        run_scn("b2b");
        check("b2b ready spacing a", (rdy_cyc.size() == 3) ? rdy_cyc[1] - rdy_cyc[0] : -1, 8);
        check("b2b ready spacing b", (rdy_cyc.size() == 3) ? rdy_cyc[2] - rdy_cyc[1] : -1, 8);

        // Contention with single-byte frames on both requesters
        flush_src();
        push(0, 8'h10, 1); push(0, 8'h20, 1);
        push(1, 8'h30, 1); push(1, 8'h40, 1);
        run_scn("contend");

        // Underrun: owner offers only the first byte of a two-byte frame
        flush_src();
        clear_mon();
        push(0, 8'h3C, 0);
        drive();
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            step();
            if (obs_fall.size() > 0 && !bus.busy) begin ok = 1; break; end
        end
        check("underrun completes", 32'(ok), 32'd1);
        check("underrun pulses", und_cnt, 1);
        check("underrun at enable fall", (obs_fall.size() > 0) ? und_cyc - obs_fall[0] : -1, 0);
        check("underrun enable len", (obs_len.size() > 0) ? obs_len[0] : -1, 8);
        check("underrun ready pulses", rdy_cyc.size(), 1);
        check("underrun byte", (obs_bytes.size() > 0) ? obs_bytes[0] : 8'h00, 8'h3C);
`ifndef SPI_ARB_FIXED_PRIO_EN
        mdl_ptr = 1;
`endif

        // Reset at bit 4 of the second byte
        flush_src();
        clear_mon();
        push(1, 8'h11, 0); push(1, 8'h22, 0); push(1, 8'h33, 1);
        drive();
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            step();
            if (prev_en && fr_len >= 12) begin ok = 1; break; end
        end
        check("midreset reached", 32'(ok), 32'd1);
        rst = 1'b1;
        #1;
        check("midreset grant",      bus.grant,      '0);
        check("midreset busy",       bus.busy,       0);
        check("midreset req_ready",  bus.req_ready,  '0);
        check("midreset underrun",   bus.underrun,   0);
        check("midreset spi_data",   bus.spi_data,   8'h00);
        check("midreset spi_enable", bus.spi_enable, 0);
        flush_src();
        drive();
        step();
        step();
        check("midreset no underrun", und_cnt, 0);
        rst = 1'b0;
        mdl_ptr = 0;
        push(0, 8'h5A, 1);
        push(1, 8'hC3, 1);
        run_scn("post_reset");

        // Randomized frame mixes
        for (int r = 0; r < 6; r++) begin
            flush_src();
            for (int q = 0; q < NR; q++) begin
                nfr = $urandom_range(0, 2);
                for (int f = 0; f < nfr; f++) begin
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) push(q, 8'($urandom), b == len - 1);
                end
            end
            if (all_empty()) push(int'($urandom_range(0, NR - 1)), 8'($urandom), 1);
            run_scn($sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
